// File: rtl/registered_crossbar.sv
// Registered N x N crossbar with a round-robin arbiter per output.
// Each input presents one flit with a one-hot output select; each output
// independently grants one eligible input per cycle and registers the flit.
//
// Handshake: an input flit moves when in_valid[j]=1 and in_grant[j]=1 in the
// same cycle (in_grant is combinational from inputs and current state). An
// output flit moves when out_valid[o]=1 and out_ready[o]=1 in the same cycle;
// out_data[o] holds steady while out_valid[o]=1 and out_ready[o]=0.
module registered_crossbar #(
    parameter int NUM_PORTS  = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_PORTS-1:0]                   in_valid,
    input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]    in_req,
    output logic [NUM_PORTS-1:0]                   in_grant,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   out_data,
    output logic [NUM_PORTS-1:0]                   out_valid,
    input  logic [NUM_PORTS-1:0]                   out_ready,
    output logic                                   req_err
);

    localparam int                    PW   = $clog2(NUM_PORTS);
    localparam logic [NUM_PORTS-1:0]  ONE  = NUM_PORTS'(1);
    localparam logic [PW-1:0]         LAST = PW'(NUM_PORTS - 1);

    logic [NUM_PORTS-1:0]                  well_formed;
    logic [NUM_PORTS-1:0]                  malformed;
    logic [NUM_PORTS-1:0]                  win_valid;
    logic [NUM_PORTS-1:0][PW-1:0]          win_idx;
    logic [NUM_PORTS-1:0]                  grant_raw;

    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [NUM_PORTS-1:0]                  out_valid_q, out_valid_d;
    logic [NUM_PORTS-1:0][PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic                                  req_err_q, req_err_d;

    // Classify each input request: exactly one select bit is well-formed.
    always_comb begin
        well_formed = '0;
        malformed   = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (in_valid[j]) begin
                if ((in_req[j] != '0) && ((in_req[j] & (in_req[j] - ONE)) == '0)) begin
                    well_formed[j] = 1'b1;
                end else begin
                    malformed[j] = 1'b1;
                end
            end
        end
    end

    // Per-output round-robin search starting at rr_ptr, wrapping at NUM_PORTS-1.
    always_comb begin
        int            idx;
        logic [PW-1:0] sel;
        win_valid = '0;
        win_idx   = '0;
        idx       = 0;
        sel       = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (!out_valid_q[o] || out_ready[o]) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    idx = int'(rr_ptr_q[o]) + k;
                    if (idx >= NUM_PORTS) begin
                        idx = idx - NUM_PORTS;
                    end
                    sel = PW'(idx);
                    if (!win_valid[o] && well_formed[sel] && in_req[sel][o]) begin
                        win_valid[o] = 1'b1;
                        win_idx[o]   = sel;
                    end
                end
            end
        end
    end

    // Fold per-output winners back onto the inputs; suppressed during reset.
    always_comb begin
        grant_raw = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (win_valid[o]) begin
                grant_raw[win_idx[o]] = 1'b1;
            end
        end
        in_grant = rst_n ? grant_raw : '0;
    end

    // Next state: load on grant, drain on ready, otherwise hold.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (win_valid[o]) begin
                out_valid_d[o] = 1'b1;
                out_data_d[o]  = in_data[win_idx[o]];
                rr_ptr_d[o]    = (win_idx[o] == LAST) ? '0 : win_idx[o] + PW'(1);
            end else if (out_ready[o]) begin
                out_valid_d[o] = 1'b0;
            end
        end
        req_err_d = req_err_q | (|malformed);
    end

    // State registers with asynchronous reset discarding any held flits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= '0;
            rr_ptr_q    <= '0;
            req_err_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
            req_err_q   <= req_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign req_err   = req_err_q;

endmodule

// File: tb/tb_registered_crossbar.sv
// Self-checking bench for registered_crossbar: directed scenarios plus
// randomized traffic compared against a behavioural model of the crossbar.
module tb_registered_crossbar;

    localparam int N = 5;
    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [N-1:0][W-1:0]   in_data;
    logic [N-1:0]          in_valid;
    logic [N-1:0][N-1:0]   in_req;
    logic [N-1:0]          in_grant;
    logic [N-1:0][W-1:0]   out_data;
    logic [N-1:0]          out_valid;
    logic [N-1:0]          out_ready;
    logic                  req_err;

    always #5 clk = ~clk;

    registered_crossbar #(.NUM_PORTS(N), .DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_req    (in_req),
        .in_grant  (in_grant),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .req_err   (req_err)
    );

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] exp_q[$];

    // Behavioural model: per-output pointer, held flag and held data.
    int           m_ptr[N];
    logic [N-1:0] m_valid;
    logic [W-1:0] m_data[N];
    logic         m_err;
    logic [N-1:0] last_grant;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [N-1:0] onehot(input int o);
        logic [N-1:0] v;
        v = N'(1) << o;
        return v;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < N; o++) begin
            m_ptr[o]  = 0;
            m_data[o] = '0;
        end
        m_valid = '0;
        m_err   = 1'b0;
    endtask

    // Compute this cycle's grants from the rules, then advance the model.
    task automatic model_step(output logic [N-1:0] g);
        int src[N];
        g = '0;
        for (int o = 0; o < N; o++) begin
            src[o] = -1;
            if (!m_valid[o] || out_ready[o]) begin
                for (int k = 0; k < N; k++) begin
                    int j;
                    j = (m_ptr[o] + k) % N;
                    if (src[o] < 0 && in_valid[j] && $countones(in_req[j]) == 1 && in_req[j][o])
                        src[o] = j;
                end
            end
        end
        for (int o = 0; o < N; o++) begin
            if (src[o] >= 0) begin
                g[src[o]]  = 1'b1;
                m_data[o]  = in_data[src[o]];
                m_valid[o] = 1'b1;
                m_ptr[o]   = (src[o] + 1) % N;
            end else if (out_ready[o]) begin
                m_valid[o] = 1'b0;
            end
        end
        for (int j = 0; j < N; j++)
            if (in_valid[j] && $countones(in_req[j]) != 1) m_err = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        in_valid  = '0;
        in_req    = '0;
        in_data   = '0;
        out_ready = '1;
    endtask

    // One clock: check grants mid-cycle, then the registered outputs after the edge.
    task automatic cycle();
        logic [N-1:0] g;
        @(negedge clk);
        model_step(g);
        check("in_grant", 64'(in_grant), 64'(g));
        last_grant = in_grant;
        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        for (int o = 0; o < N; o++)
            check($sformatf("out_data[%0d]", o), 64'(out_data[o]), 64'(m_data[o]));
        check("req_err", 64'(req_err), 64'(m_err));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        idle();
        in_valid[0] = 1'b1;
        in_req[0]   = onehot(0);
        model_reset();
        #2;
        check("reset_valid", 64'(out_valid), 64'(0));
        check("reset_data", 64'(|out_data), 64'(0));
        check("reset_err", 64'(req_err), 64'(0));
        check("reset_grant", 64'(in_grant), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();

        // Single flit 0 -> 2
        in_valid[0] = 1'b1;
        in_req[0]   = 5'b00100;
        in_data[0]  = 32'hA5A5_0001;
        #1;
        check("sf_grant", 64'(in_grant), 64'(5'b00001));
        cycle();
        check("sf_valid", 64'(out_valid[2]), 64'(1));
        check("sf_data", 64'(out_data[2]), 64'(32'hA5A5_0001));
        idle();
        cycle();
        check("sf_drop", 64'(out_valid[2]), 64'(0));

        // Fairness: 0, 1, 3 contend for output 4
        idle();
        foreach (in_valid[j]) if (j == 0 || j == 1 || j == 3) begin
            in_valid[j] = 1'b1;
            in_req[j]   = onehot(4);
            in_data[j]  = 32'h4400_0000 | (j << 16);
        end
        exp_q = '{0, 1, 3, 0, 1, 3};
        for (int c = 0; c < 6; c++) begin
            int gi;
            #1;
            gi = -1;
            for (int j = 0; j < N; j++) if (in_grant[j]) gi = j;
            check("fair_onehot", 64'($countones(in_grant)), 64'(1));
            check("fair_order", 64'(gi), 64'(exp_q.pop_front()));
            cycle();
            check("fair_valid", 64'(out_valid[4]), 64'(1));
            if (gi >= 0) in_data[gi] = in_data[gi] + 1;
        end
        idle();
        cycle();

        // Backpressure on output 1
        idle();
        out_ready[1] = 1'b0;
        in_valid[0]  = 1'b1;
        in_req[0]    = onehot(1);
        in_data[0]   = 32'h1111_0000;
        cycle();
        idle();
        out_ready[1] = 1'b0;
        in_valid[2]  = 1'b1;
        in_req[2]    = onehot(1);
        in_data[2]   = 32'h2222_0000;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_nogrant", 64'(in_grant[2]), 64'(0));
            cycle();
            check("bp_stable", 64'(out_data[1]), 64'(32'h1111_0000));
        end
        out_ready[1] = 1'b1;
        #1;
        check("bp_grant", 64'(in_grant[2]), 64'(1));
        cycle();
        check("bp_valid", 64'(out_valid[1]), 64'(1));
        check("bp_data", 64'(out_data[1]), 64'(32'h2222_0000));
        idle();
        cycle();

        // Malformed request
        idle();
        in_valid[3] = 1'b1;
        in_req[3]   = 5'b00110;
        #1;
        check("mf_nogrant", 64'(in_grant[3]), 64'(0));
        check("mf_err_before", 64'(req_err), 64'(0));
        cycle();
        check("mf_err", 64'(req_err), 64'(1));
        idle();
        repeat (3) cycle();
        check("mf_sticky", 64'(req_err), 64'(1));

        // Reset mid-operation with outputs 0, 2, 4 held
        idle();
        out_ready = 5'b01010;
        in_valid[0] = 1'b1; in_req[0] = onehot(0); in_data[0] = 32'hC000_0000;
        in_valid[1] = 1'b1; in_req[1] = onehot(2); in_data[1] = 32'hC000_0002;
        in_valid[2] = 1'b1; in_req[2] = onehot(4); in_data[2] = 32'hC000_0004;
        cycle();
        check("rst_pre", 64'(out_valid), 64'(5'b10101));
        in_valid[3] = 1'b1; in_req[3] = onehot(1); in_data[3] = 32'hC000_0001;
        rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_data", 64'(|out_data), 64'(0));
        check("rst_err", 64'(req_err), 64'(0));
        check("rst_grant", 64'(in_grant), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        check("rst_hold_valid", 64'(out_valid), 64'(0));
        idle();
        rst_n = 1'b1;
        in_valid[0] = 1'b1; in_req[0] = onehot(3); in_data[0] = 32'hD000_0000;
        in_valid[2] = 1'b1; in_req[2] = onehot(3); in_data[2] = 32'hD000_0002;
        #1;
        check("rst_first", 64'(in_grant), 64'(5'b00001));
        cycle();
        check("rst_first_data", 64'(out_data[3]), 64'(32'hD000_0000));
        in_valid[0] = 1'b0;
        in_req[0]   = '0;
        #1;
        check("rst_second", 64'(in_grant), 64'(5'b00100));
        cycle();
        check("rst_second_data", 64'(out_data[3]), 64'(32'hD000_0002));
        idle();
        cycle();

        // Parallel traffic 0->1, 1->0, 2->3, 4->2
        idle();
        in_valid[0] = 1'b1; in_req[0] = onehot(1); in_data[0] = 32'hE000_0001;
        in_valid[1] = 1'b1; in_req[1] = onehot(0); in_data[1] = 32'hE000_0010;
        in_valid[2] = 1'b1; in_req[2] = onehot(3); in_data[2] = 32'hE000_0023;
        in_valid[4] = 1'b1; in_req[4] = onehot(2); in_data[4] = 32'hE000_0042;
        #1;
        check("par_grant", 64'(in_grant), 64'(5'b10111));
        cycle();
        check("par_valid", 64'(out_valid & 5'b01111), 64'(5'b01111));
        check("par_d1", 64'(out_data[1]), 64'(32'hE000_0001));
        check("par_d0", 64'(out_data[0]), 64'(32'hE000_0010));
        check("par_d3", 64'(out_data[3]), 64'(32'hE000_0023));
        check("par_d2", 64'(out_data[2]), 64'(32'hE000_0042));
        idle();
        cycle();

        // Randomized traffic; sources hold well-formed flits until granted
        last_grant = '0;
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < N; j++) begin
                if (!in_valid[j] || last_grant[j] || $countones(in_req[j]) != 1) begin
                    int r;
                    r = int'($urandom_range(0, 99));
                    in_data[j] = $urandom;
                    if (r < 40) begin
                        in_valid[j] = 1'b0;
                        in_req[j]   = onehot(int'($urandom_range(0, N-1)));
                    end else if (r < 97) begin
                        in_valid[j] = 1'b1;
                        in_req[j]   = onehot(int'($urandom_range(0, N-1)));
                    end else begin
                        int a;
                        a = int'($urandom_range(0, N-1));
                        in_valid[j] = 1'b1;
                        in_req[j]   = (r == 99) ? '0
                                    : (onehot(a) | onehot((a + 1 + int'($urandom_range(0, N-2))) % N));
                    end
                end
            end
            out_ready = N'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
